// File: rtl/mult4_pkg.sv
// Shared definitions for the round-robin shared 4x4 multiplier scheduler.
//   state_t : scheduler FSM states. S_MUL2 is only reachable when the
//             MULT4_SCHED_OUT_PIPE_EN output pipeline stage is built in.
//   OPW     : operand width.
//   PRODW   : product width. 15*15 = 225 fits, so there is no overflow.
package mult4_pkg;

  localparam int OPW   = 4;
  localparam int PRODW = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_MUL2 = 2'd2,
    S_HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/mult4_array.sv
// Combinational 4x4 unsigned array multiplier (shared datapath).
// Ports:
//   a, b : OPW-bit unsigned operands
//   p    : PRODW-bit exact product
module mult4_array
  import mult4_pkg::*;
(
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  output logic [PRODW-1:0] p
);

  logic [PRODW-1:0] pp0, pp1, pp2, pp3;

  // One shifted partial-product row per multiplier bit, then sum the rows.
  assign pp0 = b[0] ? PRODW'(a)       : '0;
  assign pp1 = b[1] ? PRODW'(a) << 1  : '0;
  assign pp2 = b[2] ? PRODW'(a) << 2  : '0;
  assign pp3 = b[3] ? PRODW'(a) << 3  : '0;

  assign p = pp0 + pp1 + pp2 + pp3;

endmodule

// File: rtl/mult4_rr_arb.sv
// Combinational round-robin arbiter.
// Ports:
//   req   : request vector, one bit per requester
//   ptr   : highest-priority index; search starts here and wraps
//   grant : one-hot grant (all zero when nothing requests)
//   idx   : index of the granted requester
//   found : at least one request was present
module mult4_rr_arb #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            found
);

  always_comb begin
    int cand;
    // NOTE: every signal driven here gets a default first, so no path
    // through the block can leave one unassigned and infer a latch.
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        idx         = IDW'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult4_rr_sched.sv
// Round-robin scheduler sharing one combinational 4x4 multiplier among NREQ
// requesters. A grant captures the winner's operands, the multiply runs from
// the capture register, and the tagged product is held until res_ready.
// Optional build macro: MULT4_SCHED_OUT_PIPE_EN adds the S_MUL2 stage that
// registers the multiplier output (latency N+3, one result per 3 cycles).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_valid    : per-requester operand pair pending
//   req_a, req_b : operands, requester i at [4*i +: 4]
//   req_ready    : one-hot, one-cycle acceptance pulse
//   res_valid    : result held valid
//   res_ready    : consumer accepts result
//   res_prod     : product a*b
//   res_id       : requester index that issued the product
//   busy         : FSM not idle
//   op_cnt       : completed result handshakes, wraps silently
module mult4_rr_sched
  import mult4_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDW   = $clog2(NREQ),
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [OPW*NREQ-1:0] req_a,
  input  logic [OPW*NREQ-1:0] req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [PRODW-1:0]    res_prod,
  output logic [IDW-1:0]      res_id,
  output logic                busy,
  output logic [CNT_W-1:0]    op_cnt
);

  state_t           state, state_d;
  logic [IDW-1:0]   ptr;
  logic [OPW-1:0]   cap_a, cap_b;
  logic [IDW-1:0]   cap_id;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_found;
  logic             accept_en, accept, handshake;
  logic [PRODW-1:0] prod;
`ifdef MULT4_SCHED_OUT_PIPE_EN
  logic [PRODW-1:0] mid_prod;
`endif

  mult4_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gnt_idx),
    .found (gnt_found)
  );

  mult4_array u_mult (
    .a (cap_a),
    .b (cap_b),
    .p (prod)
  );

  assign handshake = (state == S_HOLD) && res_ready;
  // req_ready is combinational, so it is gated with rst_n to stay low
  // while reset is asserted even if requesters keep driving valid.
  assign accept_en = rst_n && ((state == S_IDLE) || handshake);
  assign accept    = accept_en && gnt_found;
  assign req_ready = accept_en ? grant : '0;
  assign res_valid = (state == S_HOLD);
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (accept) state_d = S_MUL;
`ifdef MULT4_SCHED_OUT_PIPE_EN
      S_MUL:  state_d = S_MUL2;
      S_MUL2: state_d = S_HOLD;
`else
      S_MUL:  state_d = S_HOLD;
`endif
      S_HOLD: if (res_ready) state_d = accept ? S_MUL : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ptr      <= '0;
      cap_a    <= '0;
      cap_b    <= '0;
      cap_id   <= '0;
      res_prod <= '0;
      res_id   <= '0;
      op_cnt   <= '0;
`ifdef MULT4_SCHED_OUT_PIPE_EN
      mid_prod <= '0;
`endif
    end else begin
      state <= state_d;
      if (accept) begin
        cap_a  <= req_a[OPW*gnt_idx +: OPW];
        cap_b  <= req_b[OPW*gnt_idx +: OPW];
        cap_id <= gnt_idx;
        ptr    <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
`ifdef MULT4_SCHED_OUT_PIPE_EN
      if (state == S_MUL) mid_prod <= prod;
      if (state == S_MUL2) begin
        res_prod <= mid_prod;
        res_id   <= cap_id;
      end
`else
      if (state == S_MUL) begin
        res_prod <= prod;
        res_id   <= cap_id;
      end
`endif
      if (handshake) op_cnt <= op_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mult4_rr_sched.sv
// Self-checking bench for mult4_rr_sched (NREQ=2, CNT_W=4 so the counter
// wrap is reachable in a short run). Inputs change at negedge/after posedge;
// outputs are sampled one time unit after the negedge.
module tb_mult4_rr_sched;

`ifdef MULT4_SCHED_OUT_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [7:0] req_a, req_b;
  logic [1:0] req_ready;
  logic       res_valid, res_ready;
  logic [7:0] res_prod;
  logic       res_id;
  logic       busy;
  logic [3:0] op_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] valid;
    logic [3:0] a0, b0, a1, b1;
    logic       exp_id;
    logic [7:0] exp_prod;
  } vec_t;

  vec_t vecs [8];

  mult4_rr_sched #(.NREQ(2), .IDW(1), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_prod  (res_prod),
    .res_id    (res_id),
    .busy      (busy),
    .op_cnt    (op_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [3:0] a0, b0, a1, b1);
    req_a = {a1, a0};
    req_b = {b1, b0};
  endtask

  // Called just after the accept edge; walks to the first result cycle,
  // checking res_valid stays low on the way.
  task automatic wait_result(input string name);
    for (int k = 1; k < LAT; k++) begin
      tick();
      check({name, "_lat_valid"}, res_valid, 0);
    end
    tick();
  endtask

  // Single operation from IDLE, ending back in IDLE after the handshake.
  task automatic do_op(input string name, input vec_t v);
    set_ops(v.a0, v.b0, v.a1, v.b1);
    req_valid = v.valid;
    #1;
    check({name, "_ready"}, req_ready, 32'(2'b01 << v.exp_id));
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_result(name);
    check({name, "_valid"}, res_valid, 1);
    check({name, "_prod"}, res_prod, v.exp_prod);
    check({name, "_id"}, res_id, v.exp_id);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  logic       rr_id   [4];
  logic [7:0] rr_prod [4];
  logic [3:0] cnt_before;

  initial begin
    vecs[0] = '{2'b01, 4'd15, 4'd15, 4'd0,  4'd0,  1'b0, 8'd225};
    vecs[1] = '{2'b01, 4'd0,  4'd9,  4'd0,  4'd0,  1'b0, 8'd0};
    vecs[2] = '{2'b11, 4'd2,  4'd3,  4'd7,  4'd8,  1'b1, 8'd56};
    vecs[3] = '{2'b11, 4'd15, 4'd1,  4'd1,  4'd15, 1'b0, 8'd15};
    vecs[4] = '{2'b10, 4'd0,  4'd0,  4'd12, 4'd12, 1'b1, 8'd144};
    vecs[5] = '{2'b10, 4'd0,  4'd0,  4'd15, 4'd0,  1'b1, 8'd0};
    vecs[6] = '{2'b11, 4'd9,  4'd7,  4'd1,  4'd1,  1'b0, 8'd63};
    vecs[7] = '{2'b01, 4'd1,  4'd1,  4'd0,  4'd0,  1'b0, 8'd1};
    rr_id   = '{1'b0, 1'b1, 1'b0, 1'b1};
    rr_prod = '{8'h0F, 8'h32, 8'h0F, 8'hE1};

    // Reset with traffic present.
    rst_n = 1'b0;
    res_ready = 1'b0;
    req_valid = 2'b11;
    set_ops(3, 5, 5, 10);
    tick(); tick();
    check("rst_ready", req_ready, 0);
    check("rst_valid", res_valid, 0);
    check("rst_prod", res_prod, 0);
    check("rst_id", res_id, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", op_cnt, 0);
    rst_n = 1'b1;
    #1;
    check("rst_first_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("async_busy", busy, 0);
    check("async_ready", req_ready, 0);
    check("async_valid", res_valid, 0);
    tick();
    req_valid = 2'b00;
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("discard_valid", res_valid, 0);
    check("discard_prod", res_prod, 0);
    check("discard_cnt", op_cnt, 0);

    // Single op 3*5 plus backpressure with req1 waiting.
    set_ops(3, 5, 5, 10);
    req_valid = 2'b01;
    #1;
    check("t2_ready", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_result("t2");
    check("t2_valid", res_valid, 1);
    check("t2_prod", res_prod, 15);
    check("t2_id", res_id, 0);
    req_valid = 2'b10;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_ready", req_ready, 0);
      check("bp_valid", res_valid, 1);
      check("bp_prod", res_prod, 15);
      check("bp_id", res_id, 0);
    end
    res_ready = 1'b1;
    #1;
    check("bp_accept_same_cycle", req_ready, 2'b10);
    @(posedge clk); #1;
    res_ready = 1'b0;
    req_valid = 2'b00;
    check("bp_cnt", op_cnt, 1);
    wait_result("bp2");
    check("bp2_prod", res_prod, 8'h32);
    check("bp2_id", res_id, 1);

    // Round-robin with both requesters continuously valid.
    res_ready = 1'b1;
    req_valid = 2'b11;
    set_ops(3, 5, 5, 10);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rr_ready", req_ready, 32'(2'b01 << rr_id[i]));
      @(posedge clk); #1;
      if (rr_id[i]) set_ops(3, 5, 15, 15);
      wait_result("rr");
      check("rr_valid", res_valid, 1);
      check("rr_prod", res_prod, rr_prod[i]);
      check("rr_id", res_id, rr_id[i]);
    end
    req_valid = 2'b00;
    tick();
    res_ready = 1'b0;
    check("rr_idle_busy", busy, 0);
    check("rr_idle_valid", res_valid, 0);
    check("rr_cnt", op_cnt, 6);

    // Table-driven single operations; ids follow the rotating pointer.
    for (int i = 0; i < 8; i++) do_op($sformatf("vec%0d", i), vecs[i]);
    check("tbl_cnt", op_cnt, 14);

    // Max operands and counter wrap.
    do_op("wrap_a", '{2'b01, 4'd15, 4'd15, 4'd0, 4'd0, 1'b0, 8'd225});
    check("cnt_15", op_cnt, 15);
    cnt_before = op_cnt;
    do_op("wrap_b", '{2'b01, 4'd15, 4'd15, 4'd0, 4'd0, 1'b0, 8'd225});
    check("cnt_wrap", op_cnt, 0);

    // Request raised and dropped while the result is held: never granted.
    set_ops(4, 4, 6, 6);
    req_valid = 2'b01;
    #1;
    check("drop_ready0", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b10;
    wait_result("drop");
    check("drop_prod", res_prod, 16);
    tick();
    check("drop_no_ready", req_ready, 0);
    req_valid = 2'b00;
    res_ready = 1'b1;
    #1;
    check("drop_hs_ready", req_ready, 0);
    tick();
    res_ready = 1'b0;
    check("drop_idle", busy, 0);
    check("drop_cnt", op_cnt, 1);
    tick();
    check("drop_still_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
